// File: rtl/sumlatch_uart_tx_pkg.sv
// Shared state encoding and UART framing constants for sumlatch_uart_tx.
// Optional 8E1 framing is enabled with the SUMLATCH_PARITY_EN macro.
package sumlatch_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam int unsigned FRAME_DATA_BITS = 8;
  localparam logic        TX_IDLE         = 1'b1;
  localparam logic        START_BIT       = 1'b0;

endpackage

// File: rtl/sumlatch_uart_tx_if.sv
// Operand/result/serial signal bundle between the pin wrapper and sumlatch_uart_tx.
interface sumlatch_uart_tx_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned SUM_W  = 16
) ();

  logic              ena;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              mode;
  logic              latch;
  logic [SUM_W-1:0]  sum_q;
  logic              ovf;
  logic              busy;
  logic              tx;

  modport master (
    output ena, op_a, op_b, mode, latch,
    input  sum_q, ovf, busy, tx
  );

  modport slave (
    input  ena, op_a, op_b, mode, latch,
    output sum_q, ovf, busy, tx
  );

endinterface

// File: rtl/sumlatch_uart_tx_byte.sv
// Single-byte UART serialiser (start, 8 data LSB first, optional even parity, stop).
// SUMLATCH_PARITY_EN inserts the PARITY bit between DATA and STOP.
module uart_tx_byte
  import sumlatch_pkg::*;
#(
  parameter int unsigned CLK_DIV = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_byte_valid,
  input  logic [7:0] i_byte_data,
  output logic       o_byte_ready_c,
  output logic       o_frame_done_c,
  output logic       o_tx
);

  localparam int unsigned CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned IDX_W = $clog2(FRAME_DATA_BITS);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(FRAME_DATA_BITS - 1);

  tx_state_e                  r_state;
  logic [CNT_W-1:0]           r_baud_cnt;
  logic [IDX_W-1:0]           r_bit_idx;
  logic [FRAME_DATA_BITS-1:0] r_shift;
  logic                       r_tx;
`ifdef SUMLATCH_PARITY_EN
  logic                       r_parity;
`endif

  logic w_baud_end;
  logic w_frame_done;
  logic w_load;

  assign w_baud_end     = (r_baud_cnt == BAUD_LAST);
  assign w_frame_done   = (r_state == STOP) && w_baud_end;
  // Ready at the last stop cycle too, so consecutive frames run back to back.
  assign o_byte_ready_c = (r_state == IDLE) || w_frame_done;
  assign o_frame_done_c = w_frame_done;
  assign w_load         = o_byte_ready_c && i_byte_valid;
  assign o_tx           = r_tx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_tx       <= TX_IDLE;
`ifdef SUMLATCH_PARITY_EN
      r_parity   <= 1'b0;
`endif
    end else if (w_load) begin
      r_state    <= START;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= i_byte_data;
      r_tx       <= START_BIT;
`ifdef SUMLATCH_PARITY_EN
      r_parity   <= ^i_byte_data;
`endif
    end else begin
      if (r_state != IDLE) begin
        r_baud_cnt <= w_baud_end ? '0 : r_baud_cnt + CNT_W'(1);
      end
      case (r_state)
        IDLE: begin
          r_tx <= TX_IDLE;
        end
        START: begin
          if (w_baud_end) begin
            r_state <= DATA;
            r_tx    <= r_shift[0];
          end
        end
        DATA: begin
          if (w_baud_end) begin
            if (r_bit_idx == IDX_LAST) begin
`ifdef SUMLATCH_PARITY_EN
              r_state <= PARITY;
              r_tx    <= r_parity;
`else
              r_state <= STOP;
              r_tx    <= TX_IDLE;
`endif
            end else begin
              r_bit_idx <= r_bit_idx + IDX_W'(1);
              r_shift   <= r_shift >> 1;
              r_tx      <= r_shift[1];
            end
          end
        end
`ifdef SUMLATCH_PARITY_EN
        PARITY: begin
          if (w_baud_end) begin
            r_state <= STOP;
            r_tx    <= TX_IDLE;
          end
        end
`endif
        STOP: begin
          if (w_baud_end) begin
            r_state <= IDLE;
            r_tx    <= TX_IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_tx    <= TX_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/sumlatch_uart_tx.sv
// Latches a load sum or running accumulation and sends it LSB-byte-first over UART.
// Define SUMLATCH_PARITY_EN for 8E1 frames; default is 8N1.
module sumlatch_uart_tx
  import sumlatch_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned SUM_W   = 16,
  parameter int unsigned CLK_DIV = 434
) (
  input  logic              clk,
  input  logic              rst_n,
  sumlatch_uart_tx_if.slave bus
);

  localparam int unsigned NBYTES = SUM_W / 8;
  localparam int unsigned LEFT_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  logic              r_latch_d;
  logic [SUM_W-1:0]  r_sum;
  logic              r_ovf;
  logic              r_busy;
  logic [SUM_W-1:0]  r_snap;
  logic [LEFT_W-1:0] r_left;

  logic             w_accept;
  logic [SUM_W-1:0] w_load_sum;
  logic [SUM_W:0]   w_acc_sum;
  logic [SUM_W-1:0] w_result;
  logic             w_byte_valid;
  logic [7:0]       w_byte_data;
  logic             w_byte_ready;
  logic             w_frame_done;
  logic             w_tx;

  assign w_accept   = bus.latch && !r_latch_d && bus.ena && !r_busy;
  assign w_load_sum = SUM_W'(bus.op_a) + SUM_W'(bus.op_b);
  assign w_acc_sum  = {1'b0, r_sum} + (SUM_W + 1)'(bus.op_a);
  assign w_result   = bus.mode ? w_acc_sum[SUM_W-1:0] : w_load_sum;

  // Byte 0 goes straight from the fresh result so START begins the cycle after acceptance.
  assign w_byte_valid = w_accept || (r_busy && (r_left != '0));
  assign w_byte_data  = w_accept ? w_result[7:0] : r_snap[7:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_latch_d <= 1'b0;
      r_sum     <= '0;
      r_ovf     <= 1'b0;
      r_busy    <= 1'b0;
      r_snap    <= '0;
      r_left    <= '0;
    end else begin
      r_latch_d <= bus.latch;
      if (w_accept) begin
        r_sum  <= w_result;
        r_ovf  <= r_ovf | (bus.mode & w_acc_sum[SUM_W]);
        r_snap <= w_result >> 8;
        r_left <= LEFT_W'(NBYTES - 1);
        r_busy <= 1'b1;
      end else if (r_busy && w_frame_done) begin
        // Either hand over the next byte or finish after the final stop bit.
        if (r_left == '0) begin
          r_busy <= 1'b0;
        end else begin
          r_left <= r_left - LEFT_W'(1);
          r_snap <= r_snap >> 8;
        end
      end
    end
  end

  uart_tx_byte #(
    .CLK_DIV (CLK_DIV)
  ) u_tx_byte (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_byte_valid   (w_byte_valid),
    .i_byte_data    (w_byte_data),
    .o_byte_ready_c (w_byte_ready),
    .o_frame_done_c (w_frame_done),
    .o_tx           (w_tx)
  );

  assign bus.sum_q = r_sum;
  assign bus.ovf   = r_ovf;
  assign bus.busy  = r_busy;
  assign bus.tx    = w_tx;

  logic w_unused;
  assign w_unused = w_byte_ready;

endmodule

// File: tb/tb_sumlatch_uart_tx.sv
// Self-checking bench for sumlatch_uart_tx: vector table, directed corners, random vs. model.
module tb_sumlatch_uart_tx;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned SUM_W   = 16;
  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned NBYTES  = SUM_W / 8;
`ifdef SUMLATCH_PARITY_EN
  localparam int unsigned FRAME_BITS = 11;
`else
  localparam int unsigned FRAME_BITS = 10;
`endif
  localparam int TXN_CYCLES = int'(NBYTES * FRAME_BITS * CLK_DIV);

  typedef struct {
    bit          mode;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp_sum;
    bit          exp_ovf;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  int unsigned m_sum = 0;
  bit          m_ovf = 1'b0;

  sumlatch_uart_tx_if #(.DATA_W(DATA_W), .SUM_W(SUM_W)) bus ();

  sumlatch_uart_tx #(
    .DATA_W  (DATA_W),
    .SUM_W   (SUM_W),
    .CLK_DIV (CLK_DIV)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // Expected line level k cycles after acceptance when transmitting val.
  function automatic logic exp_tx(int k, int unsigned val);
    int bitpos;
    int byt;
    int j;
    logic [7:0] by;
    bitpos = k / int'(CLK_DIV);
    byt    = bitpos / int'(FRAME_BITS);
    j      = bitpos % int'(FRAME_BITS);
    by     = 8'((val >> (8 * byt)) & 32'hFF);
    if (j == 0) return 1'b0;
    if (j <= 8) return by[j-1];
    if (FRAME_BITS == 11 && j == 9) return ^by;
    return 1'b1;
  endfunction

  function automatic void model_apply(bit mode, logic [7:0] a, logic [7:0] b);
    int unsigned t;
    if (!mode) begin
      m_sum = int'(a) + int'(b);
    end else begin
      t = m_sum + int'(a);
      if (t >= (32'd1 << SUM_W)) m_ovf = 1'b1;
      m_sum = t % (32'd1 << SUM_W);
    end
  endfunction

  // One request plus full waveform observation; m_sum/m_ovf must already hold the expected result.
  task automatic run_txn(input bit mode, input logic [7:0] a, input logic [7:0] b,
                         input int hold, input int repulse, input bit rand_ena);
    int last;
    int tx_bad;
    int busy_bad;
    int busy_len;
    bit seen_low;
    int unsigned snap;
    snap = m_sum; tx_bad = 0; busy_bad = 0; busy_len = 0; seen_low = 1'b0;
    last = TXN_CYCLES + 3;
    if (hold + 3 > last) last = hold + 3;
    if (repulse + 6 > last) last = repulse + 6;
    bus.ena = 1'b1; bus.mode = mode; bus.op_a = a; bus.op_b = b; bus.latch = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k <= last; k++) begin
      bus.latch = (k < hold) || (repulse > 0 && k >= repulse && k < repulse + 3);
      bus.op_a  = 8'($urandom);
      bus.op_b  = 8'($urandom);
      bus.mode  = 1'($urandom);
      if (rand_ena) bus.ena = 1'($urandom);
      @(negedge clk);
      if (k == 0) begin
        check("sum_q_t1", bus.sum_q, m_sum);
        check("ovf_t1", bus.ovf, m_ovf);
      end
      if (k < TXN_CYCLES) begin
        if (bus.tx !== exp_tx(k, snap)) tx_bad++;
        if (bus.busy !== 1'b1) busy_bad++;
      end else begin
        if (bus.tx !== 1'b1) tx_bad++;
        if (bus.busy !== 1'b0) busy_bad++;
      end
      if (bus.busy === 1'b1 && !seen_low) busy_len++;
      else seen_low = 1'b1;
      @(posedge clk); #1;
    end
    bus.latch = 1'b0;
    bus.ena   = 1'b1;
    @(posedge clk); #1;
    check("tx_wave_bad_cycles", tx_bad, 0);
    check("busy_wave_bad_cycles", busy_bad, 0);
    check("busy_len", busy_len, TXN_CYCLES);
    check("sum_q_hold", bus.sum_q, m_sum);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[7];
    int bad;
    tbl[0] = '{1'b0, 8'hFF, 8'h01, 16'h0100, 1'b0};
    tbl[1] = '{1'b1, 8'h20, 8'h5A, 16'h0120, 1'b0};
    tbl[2] = '{1'b0, 8'hFF, 8'hFF, 16'h01FE, 1'b0};
    tbl[3] = '{1'b1, 8'hFF, 8'h00, 16'h02FD, 1'b0};
    tbl[4] = '{1'b0, 8'hFF, 8'h04, 16'h0103, 1'b0};
    tbl[5] = '{1'b0, 8'h00, 8'h00, 16'h0000, 1'b0};
    tbl[6] = '{1'b1, 8'h80, 8'h33, 16'h0080, 1'b0};

    bus.ena = 1'b1; bus.mode = 1'b0; bus.op_a = '0; bus.op_b = '0; bus.latch = 1'b0;

    // Reset values
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_tx", bus.tx, 1'b1);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_sum_q", bus.sum_q, 16'h0000);
    check("rst_ovf", bus.ovf, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Vector table
    for (int i = 0; i < 7; i++) begin
      m_sum = int'(tbl[i].exp_sum);
      m_ovf = tbl[i].exp_ovf;
      run_txn(tbl[i].mode, tbl[i].a, tbl[i].b, 0, 0, 1'b0);
    end

    // ena low: latch edge ignored
    bus.ena = 1'b0; bus.mode = 1'b0; bus.op_a = 8'h11; bus.op_b = 8'h22; bus.latch = 1'b1;
    bad = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.busy !== 1'b0 || bus.tx !== 1'b1) bad++;
    end
    check("ena_low_activity", bad, 0);
    check("ena_low_sum_q", bus.sum_q, m_sum);
    @(posedge clk); #1;
    bus.latch = 1'b0;
    @(posedge clk); #1;
    bus.ena = 1'b1;
    @(posedge clk); #1;

    // Re-pulse mid-transmission is dropped
    model_apply(1'b0, 8'h3C, 8'hA5);
    run_txn(1'b0, 8'h3C, 8'hA5, 0, TXN_CYCLES / 2, 1'b0);
    // Level held for three frame times gives one transaction
    model_apply(1'b0, 8'h12, 8'h34);
    run_txn(1'b0, 8'h12, 8'h34, 3 * int'(FRAME_BITS * CLK_DIV), 0, 1'b0);

    // Random transactions against the model
    for (int i = 0; i < 16; i++) begin
      bit          md;
      logic [7:0]  a;
      logic [7:0]  b;
      int          v;
      md = 1'($urandom); a = 8'($urandom); b = 8'($urandom);
      v  = int'($urandom_range(0, 2));
      model_apply(md, a, b);
      if (v == 1)
        run_txn(md, a, b, 0, int'($urandom_range(2, TXN_CYCLES - 5)), 1'($urandom));
      else if (v == 2)
        run_txn(md, a, b, int'($urandom_range(1, 3 * FRAME_BITS * CLK_DIV)), 0, 1'($urandom));
      else
        run_txn(md, a, b, 0, 0, 1'($urandom));
    end

    // Reset in the middle of data bit 3 of byte 0
    bus.mode = 1'b0; bus.op_a = 8'h55; bus.op_b = 8'h00; bus.latch = 1'b1;
    @(posedge clk); #1;
    bus.latch = 1'b0;
    repeat (4 * CLK_DIV + 1) begin @(posedge clk); #1; end
    @(negedge clk);
    check("mid_frame_busy", bus.busy, 1'b1);
    check("mid_frame_bit3", bus.tx, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_tx", bus.tx, 1'b1);
    check("midrst_busy", bus.busy, 1'b0);
    check("midrst_sum_q", bus.sum_q, 16'h0000);
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_sum = 0; m_ovf = 1'b0;
    @(posedge clk); #1;
    model_apply(1'b0, 8'hC3, 8'h3D);
    run_txn(1'b0, 8'hC3, 8'h3D, 0, 0, 1'b0);

    // Climb to 0xFFF0 via accumulation, then overflow
    m_sum = 0;
    run_txn(1'b0, 8'h00, 8'h00, 0, 0, 1'b0);
    for (int i = 0; i < 256; i++) begin
      model_apply(1'b1, 8'hFF, 8'h00);
      run_txn(1'b1, 8'hFF, 8'h00, 0, 0, 1'b0);
    end
    model_apply(1'b1, 8'hF0, 8'h00);
    run_txn(1'b1, 8'hF0, 8'h00, 0, 0, 1'b0);
    check("reach_fff0", bus.sum_q, 16'hFFF0);
    check("pre_ovf", bus.ovf, 1'b0);
    model_apply(1'b1, 8'h20, 8'h00);
    run_txn(1'b1, 8'h20, 8'h00, 0, 0, 1'b0);
    check("wrap_sum_q", bus.sum_q, 16'h0010);
    check("wrap_ovf", bus.ovf, 1'b1);
    model_apply(1'b0, 8'h03, 8'h00);
    run_txn(1'b0, 8'h03, 8'h00, 0, 0, 1'b0);
    check("load_after_ovf_sum", bus.sum_q, 16'h0003);
    check("ovf_sticky", bus.ovf, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sumlatch_uart_tx.md
Name: sumlatch_uart_tx

Overview:
- Parametrised successor of the sum-latch-UART datapath behind the TinyTapeout top wrapper.
- On a latch request, computes one of two results and stores it in a result register:
  - a fresh sum of two operands, or
  - a running accumulation.
- It then serialises that result LSB-byte-first as 8N1 UART frames on a single TX pin.
- Sits between the `ui_in`/`uio_in` operand pins and `uo_out[0]` (tx) inside `tt_um_top`.

Parameters:
- DATA_W, 8: operand width. Must be at least 1.
- SUM_W, 16: result register width. Must be a multiple of 8 and at least DATA_W+1.
- CLK_DIV, 434: clock cycles per UART bit. Must be at least 2. The default gives 115200 baud at 50 MHz.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- ena  in  1  design enable. When low, new latch requests are ignored.
- op_a  in  DATA_W  operand A.
- op_b  in  DATA_W  operand B.
- mode  in  1  0 = load (op_a+op_b); 1 = accumulate (sum_q+op_a).
- latch  in  1  request level; only its rising edge acts.
- sum_q  out  SUM_W  latched result register.
- ovf  out  1  sticky overflow flag.
- busy  out  1  high while a transmission is in progress.
- tx  out  1  UART serial output; idle level is 1.

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset is synchronous and active-low on rst_n, sampled at the rising clk edge.
- Reset values: sum_q=0, ovf=0, busy=0, tx=1, FSM=IDLE, all counters=0, latch-edge register=0.
- Edge detection:
  - A register latch_d holds the previous value of latch.
  - A request is accepted in cycle t when latch=1, latch_d=0, ena=1 and FSM=IDLE.
  - A level held high produces exactly one transaction.
  - A rising edge while busy, or while ena=0, is dropped. It is not queued.
- Arithmetic, written in cycle t+1 (one-cycle latency):
  - mode=0: sum_q <= zero-extend(op_a) + zero-extend(op_b). This cannot overflow because SUM_W ≥ DATA_W+1. ovf is unchanged.
  - mode=1: sum_q <= (sum_q + zero-extend(op_a)) mod 2^SUM_W. ovf is set to 1 if a carry-out occurs.
  - ovf clears only on reset.
- FSM: IDLE -> START -> DATA -> STOP -> (next byte ? START : IDLE).
  - IDLE: tx=1, busy=0.
  - Accepted request: FSM enters START in cycle t+1, with busy=1 and tx=0 from cycle t+1.
  - START: tx=0 for CLK_DIV cycles.
  - DATA: 8 bits, LSB first, each held for CLK_DIV cycles.
  - STOP: tx=1 for CLK_DIV cycles.
- Byte order:
  - NBYTES = SUM_W/8 frames are sent back to back, byte 0 (sum_q[7:0]) first.
  - A snapshot of sum_q is taken at request acceptance and is the value transmitted.
- Timing:
  - Total busy time is exactly NBYTES*10*CLK_DIV cycles (with PARITY_EN: NBYTES*11*CLK_DIV).
  - busy falls in the cycle after the last stop bit completes.
  - A new request is accepted in the first cycle busy=0.
- ena falling mid-transmission: the transaction completes normally.
- Reset mid-frame: returns to IDLE immediately on the next edge, tx=1 and sum_q=0. No partial frame resumes.
- Operand changes after cycle t have no effect on the current transaction.

Optional Feature:
- Macro: SUMLATCH_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. It drives the even parity bit (XOR of the 8 data bits) for CLK_DIV cycles, giving 8E1 framing.
- Undefined: 8N1 framing; the PARITY state and its logic are absent.

Decomposition:
- Package sumlatch_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP);
  - the constants FRAME_DATA_BITS=8, TX_IDLE=1'b1 and START_BIT=1'b0.
- Sub-module uart_tx_byte:
  - serialises one byte with a byte_valid/byte_ready handshake;
  - owns the baud counter and bit index.
- The top-level keeps edge detection, arithmetic, ovf, the snapshot and byte sequencing.

Test Plan:
- Reset: hold rst_n=0 for 5 cycles -> tx=1, busy=0, sum_q=0, ovf=0.
- Load path: mode=0, op_a=8'hFF, op_b=8'h01, latch pulse -> sum_q=16'h0100 one cycle later; tx carries frames 0x00 then 0x01, 8N1; busy high for exactly 20*CLK_DIV cycles.
- Accumulate with overflow: reach sum_q=16'hFFF0, then mode=1, op_a=8'h20, latch -> sum_q=16'h0010, ovf=1. Then a mode=0 load -> ovf stays 1.
- Busy and ena rejection:
  - latch re-pulsed mid-transmission -> no extra frames, sum_q unchanged;
  - latch held high for 3*frame-time -> exactly one transaction;
  - ena=0 with a latch edge -> no activity.
- Reset mid-frame: assert rst_n=0 during DATA bit 3 of byte 0 -> tx=1 and busy=0 on the next edge; a subsequent request transmits cleanly.
- With SUMLATCH_PARITY_EN: load 0x0103 -> frames 0x03 (parity bit 0) and 0x01 (parity bit 1); busy for 22*CLK_DIV cycles.
